// File: rtl/eje7_secded_dec.sv
// Pipelined Hamming SECDED decoder with even overall parity, optional correction
// bypass, valid/ready handshake and saturating single/double error counters.
module eje7_secded_dec #(
    parameter  int DATA_W = 8,
    parameter  int CNT_W  = 16,
    localparam int R      = (DATA_W <= 4)  ? 3 :
                            (DATA_W <= 11) ? 4 :
                            (DATA_W <= 26) ? 5 :
                            (DATA_W <= 57) ? 6 : 7,
    localparam int CW     = DATA_W + R + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CW-1:0]     in_code,
    input  logic              corr_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sgl,
    output logic              out_dbl,
    output logic [R-1:0]      out_syn,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  cnt_sgl,
    output logic [CNT_W-1:0]  cnt_dbl
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [R-1:0]     LAST_POS = R'(CW - 1);

    // Hamming position (1-based) holding data bit j: the j-th non-power-of-two from 3 up.
    function automatic int data_pos(input int j);
        int n;
        int p;
        n = 0;
        p = 0;
        for (int q = 3; q < CW; q++) begin
            if ((q & (q - 1)) != 0) begin
                if (n == j) p = q;
                n++;
            end
        end
        return p;
    endfunction

    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic              s1_corr;
    logic [R-1:0]      s1_syn;
    logic              s1_g;

    logic adv1, adv2;
    logic out_xfer;

    assign adv2     = ~out_valid | out_ready;
    assign adv1     = ~s1_valid | adv2;
    assign in_ready = adv1;
    assign out_xfer = out_valid & out_ready;

    logic [R-1:0]      syn_c;
    logic              g_c;
    logic [DATA_W-1:0] raw_c;
    logic [DATA_W-1:0] data_c;
    logic              sgl_c;
    logic              dbl_c;

    // NOTE: every always_comb output gets a default before any conditional update, so no latch can be inferred.
    always_comb begin
        syn_c = '0;
        for (int i = 0; i < CW - 1; i++) begin
            if (in_code[i]) syn_c = syn_c ^ R'(i + 1);
        end
        g_c = ^in_code;
    end

    for (genvar j = 0; j < DATA_W; j++) begin : g_data
        localparam int P = data_pos(j);
        assign raw_c[j]  = in_code[P-1];
        // Only the data bit sitting at the syndrome position is flipped; parity flips touch no data.
        assign data_c[j] = s1_data[j] ^ (s1_corr & s1_g & (s1_syn == R'(P)));
    end

    always_comb begin
        sgl_c = s1_g & (s1_syn <= LAST_POS);
        dbl_c = (s1_g & (s1_syn > LAST_POS)) | (~s1_g & (s1_syn != '0));
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_corr  <= 1'b0;
            s1_syn   <= '0;
            s1_g     <= 1'b0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= raw_c;
                s1_corr <= corr_en;
                s1_syn  <= syn_c;
                s1_g    <= g_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sgl   <= 1'b0;
            out_dbl   <= 1'b0;
            out_syn   <= '0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= data_c;
                out_sgl  <= sgl_c;
                out_dbl  <= dbl_c;
                out_syn  <= s1_syn;
            end
        end
    end

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_sgl <= '0;
            cnt_dbl <= '0;
        end else if (clr_cnt) begin
            cnt_sgl <= '0;
            cnt_dbl <= '0;
        end else begin
            if (out_xfer && out_sgl && cnt_sgl != CNT_MAX) cnt_sgl <= cnt_sgl + 1'b1;
            if (out_xfer && out_dbl && cnt_dbl != CNT_MAX) cnt_dbl <= cnt_dbl + 1'b1;
        end
    end

endmodule

// File: tb/tb_eje7_secded_dec.sv
// Directed bench for eje7_secded_dec at DATA_W=8 (R=4, CW=13) with 2-bit counters.
module tb_eje7_secded_dec;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 2;
    localparam int R      = 4;
    localparam int CW     = 13;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [CW-1:0]     in_code = '0;
    logic              corr_en = 1'b1;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_data;
    logic              out_sgl;
    logic              out_dbl;
    logic [R-1:0]      out_syn;
    logic              clr_cnt = 1'b0;
    logic [CNT_W-1:0]  cnt_sgl;
    logic [CNT_W-1:0]  cnt_dbl;

    eje7_secded_dec #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code), .corr_en(corr_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sgl(out_sgl), .out_dbl(out_dbl), .out_syn(out_syn),
        .clr_cnt(clr_cnt), .cnt_sgl(cnt_sgl), .cnt_dbl(cnt_dbl)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          corr;
        logic [CW-1:0] code;
        logic [7:0]    data;
        logic          sgl;
        logic          dbl;
        logic [R-1:0]  syn;
    } vec_t;

    vec_t       vecs[13];
    logic [CW-1:0] st_code[8];
    logic [7:0]    st_data[8];

    // Streams n words from st_code; out_ready held low for the first `stall` cycles.
    task automatic run_stream(input int n, input logic corr, input int stall, input string tag,
                              output int stall_accepts, output int first_cyc, output int last_cyc);
        logic [7:0] expq[$];
        logic [7:0] held;
        logic       held_v;
        int sent;
        int got;
        sent = 0;
        got = 0;
        held = '0;
        held_v = 1'b0;
        stall_accepts = 0;
        first_cyc = -1;
        last_cyc = -1;
        for (int cyc = 0; cyc < 80 && got < n; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= stall);
            in_valid  = (sent < n);
            in_code   = (sent < n) ? st_code[sent] : '0;
            corr_en   = corr;
            #1;
            if (held_v) begin
                check({tag, " stall hold"}, out_data, held);
                held_v = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    check({tag, " unexpected word"}, out_data, 32'hFFFF_FFFF);
                end else begin
                    check({tag, " order"}, out_data, expq.pop_front());
                end
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                got++;
            end else if (out_valid) begin
                held   = out_data;
                held_v = 1'b1;
            end
            if (in_valid && in_ready) begin
                expq.push_back(st_data[sent]);
                sent++;
                if (cyc < stall) stall_accepts++;
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check({tag, " delivered"}, got, n);
        @(negedge clk);
        #1;
        check({tag, " no duplicate"}, out_valid, 0);
    endtask

    initial begin
        int sa, fc, lc, stale;

        vecs[0]  = '{1'b1, 13'h0A27, 8'hA5, 1'b0, 1'b0, 4'd0};
        vecs[1]  = '{1'b1, 13'h0A07, 8'hA5, 1'b1, 1'b0, 4'd6};
        vecs[2]  = '{1'b1, 13'h1A27, 8'hA5, 1'b1, 1'b0, 4'd0};
        vecs[3]  = '{1'b0, 13'h0A07, 8'hA1, 1'b1, 1'b0, 4'd6};
        vecs[4]  = '{1'b1, 13'h0A03, 8'hA0, 1'b0, 1'b1, 4'd5};
        vecs[5]  = '{1'b1, 13'h0F77, 8'hFF, 1'b0, 1'b0, 4'd0};
        vecs[6]  = '{1'b1, 13'h0550, 8'h5A, 1'b0, 1'b0, 4'd0};
        vecs[7]  = '{1'b1, 13'h0227, 8'hA5, 1'b1, 1'b0, 4'd12};
        vecs[8]  = '{1'b1, 13'h0AA7, 8'hA5, 1'b1, 1'b0, 4'd8};
        vecs[9]  = '{1'b1, 13'h1226, 8'h25, 1'b0, 1'b1, 4'd13};
        vecs[10] = '{1'b0, 13'h0A03, 8'hA0, 1'b0, 1'b1, 4'd5};
        vecs[11] = '{1'b0, 13'h1A27, 8'hA5, 1'b1, 1'b0, 4'd0};
        vecs[12] = '{1'b0, 13'h0227, 8'h25, 1'b1, 1'b0, 4'd12};

        // Reset state
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset out_valid", out_valid, 0);
        check("reset out_data", out_data, 0);
        check("reset flags", {out_sgl, out_dbl}, 0);
        check("reset out_syn", out_syn, 0);
        check("reset counters", {cnt_sgl, cnt_dbl}, 0);
        check("reset in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: one word at a time, inputs scrambled after acceptance
        foreach (vecs[k]) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_code   = vecs[k].code;
            corr_en   = vecs[k].corr;
            out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            in_code  = '1;
            corr_en  = ~vecs[k].corr;
            #1;
            check($sformatf("vec%0d latency early", k), out_valid, 0);
            @(negedge clk);
            #1;
            check($sformatf("vec%0d out_valid", k), out_valid, 1);
            check($sformatf("vec%0d out_data", k), out_data, vecs[k].data);
            check($sformatf("vec%0d sgl", k), out_sgl, vecs[k].sgl);
            check($sformatf("vec%0d dbl", k), out_dbl, vecs[k].dbl);
            check($sformatf("vec%0d syn", k), out_syn, vecs[k].syn);
        end
        @(negedge clk);
        #1;
        check("saturated cnt_sgl", cnt_sgl, 3);
        check("saturated cnt_dbl", cnt_dbl, 3);

        // Clean stream: latency 2, then one word per cycle
        for (int i = 0; i < 4; i++) begin
            st_code[i] = 13'h0A27;
            st_data[i] = 8'hA5;
        end
        run_stream(4, 1'b1, 0, "clean", sa, fc, lc);
        check("clean first out cycle", fc, 2);
        check("clean last out cycle", lc, 5);

        // Backpressure with distinct words
        st_code[0] = 13'h0A27; st_data[0] = 8'hA5;
        st_code[1] = 13'h0F77; st_data[1] = 8'hFF;
        st_code[2] = 13'h0550; st_data[2] = 8'h5A;
        st_code[3] = 13'h0000; st_data[3] = 8'h00;
        run_stream(4, 1'b1, 6, "bp", sa, fc, lc);
        check("bp accepts while stalled", sa, 2);

        // Idle clear
        @(negedge clk);
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        #1;
        check("idle clr", {cnt_sgl, cnt_dbl}, 0);

        // Five single-error words saturate a 2-bit counter
        for (int i = 0; i < 5; i++) begin
            st_code[i] = 13'h0A07;
            st_data[i] = 8'hA5;
        end
        run_stream(5, 1'b1, 0, "sat", sa, fc, lc);
        check("sat cnt_sgl", cnt_sgl, 3);
        check("sat cnt_dbl", cnt_dbl, 0);

        // clr_cnt on the transfer cycle of a double-error word
        @(negedge clk);
        in_valid = 1'b1;
        in_code  = 13'h0A03;
        corr_en  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        check("clrxfer out_dbl", out_dbl, 1);
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        #1;
        check("clrxfer cnt_dbl", cnt_dbl, 0);
        check("clrxfer cnt_sgl", cnt_sgl, 0);

        // Asynchronous reset mid-stream
        @(negedge clk);
        in_valid = 1'b1;
        in_code  = 13'h0A07;
        corr_en  = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("pre-reset cnt_sgl", cnt_sgl, 1);
        check("pre-reset out_valid", out_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        check("async reset out_valid", out_valid, 0);
        check("async reset out_data", out_data, 0);
        check("async reset flags", {out_sgl, out_dbl, out_syn}, 0);
        check("async reset counters", {cnt_sgl, cnt_dbl}, 0);
        check("async reset in_ready", in_ready, 1);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            if (out_valid) stale++;
        end
        check("no stale word after reset", stale, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/eje7_secded_dec.md
# eje7_secded_dec

Parametrised, pipelined Hamming SECDED decoder/corrector with even parity and a valid/ready stream handshake. It generalises the fixed (12,8) single-error corrector to any data width and adds an overall parity bit for double-error detection, a correction bypass, and saturating error counters. It sits on the receive side of a link, between the codeword source and the data consumer.

## Interface
- DATA_W, 8, data bits per word (4..64); derived R = smallest r with 2^r ≥ DATA_W+r+1; CW = DATA_W+R+1
- CNT_W, 16, width of each error counter
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  codeword present on in_code
- in_ready  out  1  decoder accepts in_code this cycle
- in_code  in  CW  received codeword
- corr_en  in  1  1 = correct single errors, 0 = pass raw data, flags still computed; sampled with the codeword
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_data  out  DATA_W  (corrected) data
- out_sgl  out  1  single error detected (corrected if corr_en was 1)
- out_dbl  out  1  uncorrectable error detected
- out_syn  out  R  Hamming syndrome of the word
- clr_cnt  in  1  synchronous clear of both counters
- cnt_sgl  out  CNT_W  delivered words with out_sgl=1, saturating
- cnt_dbl  out  CNT_W  delivered words with out_dbl=1, saturating

## Operation
- Codeword layout: in_code[i] is Hamming position i+1 for i = 0..CW-2; parity bits at positions 2^k (k = 0..R-1); data bits fill the remaining positions in ascending order, data[0] at position 3. in_code[CW-1] is overall parity; XOR of all CW bits is 0 for a clean word.
- s = XOR of the position numbers of all set bits at positions 1..CW-1. g = XOR of all CW bits.
- Classification:
  - s=0, g=0: clean; sgl=0, dbl=0.
  - g=1, s=0: overall parity bit in error; sgl=1; data unchanged.
  - g=1, 1≤s≤CW-1: sgl=1; the bit at position s is flipped when corr_en=1. A flip of a parity position leaves data unchanged.
  - g=1, s>CW-1: dbl=1, sgl=0.
  - g=0, s≠0: dbl=1; data passed raw.
- sgl and dbl are never both 1. out_syn = s.
- Counters increment on an output transfer (out_valid & out_ready) when the respective flag is set, and saturate at 2^CNT_W-1. clr_cnt has priority over a same-cycle increment; the counter ends at 0.

## Timing
- Two-stage pipeline. Stage 1 registers in_code, corr_en, s and g. Stage 2 registers out_data, flags and out_syn.
- Latency is 2 cycles from an accepted input to out_valid, with no bubbles. Throughput is 1 word/cycle while out_ready=1.
- Handshake:
  - Input transfer = in_valid & in_ready. Output transfer = out_valid & out_ready.
  - adv2 = ~out_valid | out_ready.
  - adv1 = ~s1_valid | adv2.
  - in_ready = adv1, combinational from registered state and out_ready; no path from in_valid.
- Stall: with out_valid=1 and out_ready=0, out_data, flags and out_syn hold stable. Stage 1 holds if full, and in_ready=0 once both stages are full.
- in_code and corr_en are ignored when in_valid=0 or in_ready=0.
- Reset (asynchronous assert, synchronous-safe deassert): both stage valids 0. out_valid=0, out_data=0, out_sgl=0, out_dbl=0, out_syn=0, cnt_sgl=0, cnt_dbl=0. in_ready=1 after reset. Words in flight at reset are discarded, not delivered.

## Test plan
DATA_W=8 (R=4, CW=13); the clean codeword for data 8'hA5 is 13'h0A27.
- Clean stream: 13'h0A27 for 4 cycles, out_ready=1 → out_data=8'hA5, sgl=dbl=0, syn=0; first out_valid 2 cycles after the first accept, then 1/cycle.
- Single errors, corr_en=1: 13'h0A07 (position 6) → A5, sgl=1, syn=6. 13'h1A27 (overall bit) → A5, sgl=1, syn=0. Same 13'h0A07 with corr_en=0 → out_data=8'hA1, sgl=1.
- Double error: 13'h0A03 (positions 3 and 6) → dbl=1, sgl=0, syn=5, out_data=8'hA0 (raw).
- Backpressure: hold out_ready=0 while streaming → in_ready=0 after 2 accepts and the output stays stable. Release → words emerge in order, none lost or duplicated.
- Counters and reset:
  - CNT_W=2: five single-error words → cnt_sgl=3 (saturated).
  - clr_cnt asserted on a transfer cycle → 0.
  - rst_n pulsed low mid-stream → all outputs 0 immediately, no stale word emitted afterwards.
